// File: rtl/sync_fifo.sv
// Single-clock FIFO with a registered read port and occupancy counter.
// Flags are decoded from the counter, so empty and full can never both be high.
module sync_fifo #(
    parameter int unsigned BUF_WIDTH  = 3,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] buf_in,
    input  logic                  wr_en,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] buf_out,
    output logic                  buf_empty,
    output logic                  buf_full,
    output logic [BUF_WIDTH:0]    fifo_counter
);

    localparam int unsigned          Depth     = 2 ** BUF_WIDTH;
    localparam logic [BUF_WIDTH:0]   FullCount = (BUF_WIDTH + 1)'(Depth);
    localparam logic [BUF_WIDTH:0]   CntOne    = (BUF_WIDTH + 1)'(1);
    localparam logic [BUF_WIDTH-1:0] PtrOne    = BUF_WIDTH'(1);

    logic [DATA_WIDTH-1:0] mem_q [Depth];
    logic [BUF_WIDTH-1:0]  wr_ptr_q, wr_ptr_d;
    logic [BUF_WIDTH-1:0]  rd_ptr_q, rd_ptr_d;
    logic [BUF_WIDTH:0]    count_q, count_d;
    logic [DATA_WIDTH-1:0] out_q, out_d;
    logic                  wr_acc, rd_acc;

    assign buf_empty    = (count_q == '0);
    assign buf_full     = (count_q == FullCount);
    assign fifo_counter = count_q;
    assign buf_out      = out_q;

    // Acceptance uses pre-edge flags: empty blocks the read, full blocks the write.
    assign wr_acc = wr_en && !buf_full;
    assign rd_acc = rd_en && !buf_empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        out_d    = out_q;
        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + PtrOne;
        end
        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + PtrOne;
            out_d    = mem_q[rd_ptr_q];
        end
        unique case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CntOne;
            2'b01:   count_d = count_q - CntOne;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            out_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            out_q    <= out_d;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem_q[wr_ptr_q] <= buf_in;
        end
    end

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo: a queue scoreboard tracks the expected contents,
// read data and occupancy, checked 1 time unit after every rising edge.
module tb_sync_fifo;

    logic       clk;
    logic       rst;
    logic [7:0] buf_in;
    logic       wr_en;
    logic       rd_en;
    logic [7:0] buf_out;
    logic       buf_empty;
    logic       buf_full;
    logic [3:0] fifo_counter;

    int         total;
    int         bad;
    logic [7:0] sb_q[$];
    logic [7:0] exp_out;

    sync_fifo #(
        .BUF_WIDTH (3),
        .DATA_WIDTH(8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .buf_in      (buf_in),
        .wr_en       (wr_en),
        .rd_en       (rd_en),
        .buf_out     (buf_out),
        .buf_empty   (buf_empty),
        .buf_full    (buf_full),
        .fifo_counter(fifo_counter)
    );

    // Clock starts late so the reset state can be observed with no edge at all.
    initial begin
        clk = 1'b0;
        #40;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, ".out"}, 32'(buf_out), 32'(exp_out));
        check({tag, ".cnt"}, 32'(fifo_counter), 32'(sb_q.size()));
        check({tag, ".empty"}, 32'(buf_empty), 32'(sb_q.size() == 0));
        check({tag, ".full"}, 32'(buf_full), 32'(sb_q.size() == 8));
    endtask

    // One clock with the given strobes; the scoreboard applies FIFO rules.
    task automatic step(input logic w, input logic [7:0] d, input logic r, input string tag);
        bit wacc;
        bit racc;
        @(negedge clk);
        wr_en  = w;
        buf_in = d;
        rd_en  = r;
        wacc   = w && (sb_q.size() < 8);
        racc   = r && (sb_q.size() > 0);
        @(posedge clk);
        if (racc) exp_out = sb_q.pop_front();
        if (wacc) sb_q.push_back(d);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        check_state(tag);
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        exp_out = 8'd0;
        rst     = 1'b0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        buf_in  = 8'd0;

        // Asynchronous reset with no clock edge yet.
        #2 rst = 1'b1;
        #15;
        check_state("reset");
        rst = 1'b0;

        // Basic write, then simultaneous write+read.
        step(1'b1, 8'd1, 1'b0, "wr1");
        step(1'b1, 8'd2, 1'b1, "wr2rd");
        check("wr2rd.buf_out", 32'(buf_out), 32'd1);

        // Fill and overflow.
        for (int i = 1; i <= 7; i++) step(1'b1, 8'(i * 10), 1'b0, "fill");
        check("fill.full", 32'(buf_full), 32'd1);
        for (int i = 8; i <= 13; i++) step(1'b1, 8'(i * 10), 1'b0, "ovf");
        check("ovf.cnt", 32'(fifo_counter), 32'd8);

        // Drain with wrap-around: 2, then write 2 back, then 10..70,2.
        step(1'b0, 8'd0, 1'b1, "rd_first");
        check("rd_first.val", 32'(buf_out), 32'd2);
        step(1'b1, 8'd2, 1'b0, "wrback");
        for (int i = 0; i < 8; i++) step(1'b0, 8'd0, 1'b1, "drain");
        check("drain.last", 32'(buf_out), 32'd2);

        // Underflow holds buf_out; write+read while empty accepts only the write.
        step(1'b0, 8'd0, 1'b1, "underflow");
        step(1'b1, 8'd5, 1'b1, "empty_wr_rd");
        check("empty_wr_rd.cnt", 32'(fifo_counter), 32'd1);
        step(1'b0, 8'd0, 1'b1, "rd5");
        check("rd5.val", 32'(buf_out), 32'd5);

        // Write+read while full: only the read is accepted.
        for (int i = 0; i < 8; i++) step(1'b1, 8'(100 + i), 1'b0, "refill");
        step(1'b1, 8'd200, 1'b1, "full_wr_rd");
        check("full_wr_rd.cnt", 32'(fifo_counter), 32'd7);
        for (int i = 0; i < 7; i++) step(1'b0, 8'd0, 1'b1, "drain2");
        check("drain2.last", 32'(buf_out), 32'd107);

        // Reset mid-operation between edges discards stored data.
        for (int i = 0; i < 3; i++) step(1'b1, 8'(40 + i), 1'b0, "pre_rst");
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        sb_q.delete();
        exp_out = 8'd0;
        check_state("mid_rst");
        rst = 1'b0;
        step(1'b1, 8'd77, 1'b0, "post_wr");
        step(1'b0, 8'd0, 1'b1, "post_rd");
        check("post_rd.val", 32'(buf_out), 32'd77);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
